// File: rtl/entry_point_dispatcher.sv
// Entry-point dispatcher: arbitrates channel triggers, reads the entry word
// from imem, presents start address + channel to the IFU. Macro: EPU_ROUND_ROBIN_EN.
//
// Ports:
//   Clock, Reset (async, active-low)
//   iTrigger / iInitialCodeAddress : per-channel launch request + table address
//   oIMemRead / oIMemAddr / iIMemInput : instruction memory read port
//   oEntryValid / iIFUReady / oEntryPoint / oEntryChannel : IFU handshake
//   oPending / oOverrun / oBusy : status
module entry_point_dispatcher #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 64,
  parameter int NUM_CH  = 4,
  parameter int MEM_LAT = 1,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        iTrigger,
  input  logic [NUM_CH*ADDR_W-1:0] iInitialCodeAddress,
  output logic                     oIMemRead,
  output logic [ADDR_W-1:0]        oIMemAddr,
  input  logic [INSTR_W-1:0]       iIMemInput,
  output logic                     oEntryValid,
  input  logic                     iIFUReady,
  output logic [ADDR_W-1:0]        oEntryPoint,
  output logic [CH_W-1:0]          oEntryChannel,
  output logic [NUM_CH-1:0]        oPending,
  output logic [NUM_CH-1:0]        oOverrun,
  output logic                     oBusy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] ovr_q, ovr_d;
  logic [NUM_CH-1:0] set, clr;
  logic [ADDR_W-1:0] addr_q [NUM_CH];
  logic [ADDR_W-1:0] cur_addr_q;
  logic [CH_W-1:0]   cur_ch_q;
  logic [ADDR_W-1:0] entry_q;
  logic [CH_W-1:0]   sel_ch;
  logic              sel_hit;
  logic              take;
  logic              cap;
  int                idx;

  // Upper memory-word bits carry no entry information.
  logic unused_mem;
  assign unused_mem = ^iIMemInput;

`ifdef EPU_ROUND_ROBIN_EN
  logic [CH_W-1:0] ptr_q;

  // Starts at the last channel so the first search begins at channel 0.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) ptr_q <= CH_W'(NUM_CH - 1);
    else if (take) ptr_q <= sel_ch;
  end
`endif

  always_comb begin
    sel_hit = 1'b0;
    sel_ch  = '0;
    idx     = 0;
    for (int i = 0; i < NUM_CH; i++) begin
`ifdef EPU_ROUND_ROBIN_EN
      idx = (int'(ptr_q) + 1 + i) % NUM_CH;
`else
      idx = i;
`endif
      if (!sel_hit && pend_q[idx]) begin
        sel_hit = 1'b1;
        sel_ch  = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;
    cap     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (sel_hit) begin
          take    = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == 2'(MEM_LAT - 1)) begin
          cap     = 1'b1;
          state_d = S_PRESENT;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_PRESENT: begin
        if (iIFUReady) begin
          if (sel_hit) begin
            take    = 1'b1;
            state_d = S_ISSUE;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A trigger landing on the channel being selected re-arms it (set wins)
  // and is not an overrun.
  always_comb begin
    clr = '0;
    for (int k = 0; k < NUM_CH; k++)
      clr[k] = take && (sel_ch == CH_W'(k));
    set    = iTrigger & (~pend_q | clr);
    ovr_d  = iTrigger & pend_q & ~clr;
    pend_d = (pend_q & ~clr) | set;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      ovr_q      <= '0;
      cur_addr_q <= '0;
      cur_ch_q   <= '0;
      entry_q    <= '0;
      for (int k = 0; k < NUM_CH; k++)
        addr_q[k] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      for (int k = 0; k < NUM_CH; k++)
        if (set[k])
          addr_q[k] <= iInitialCodeAddress[k*ADDR_W +: ADDR_W];
      if (take) begin
        cur_ch_q   <= sel_ch;
        cur_addr_q <= addr_q[sel_ch];
      end
      if (cap)
        entry_q <= iIMemInput[ADDR_W-1:0];
    end
  end

  assign oIMemRead     = (state_q == S_ISSUE);
  assign oIMemAddr     = oIMemRead ? cur_addr_q : '0;
  assign oEntryValid   = (state_q == S_PRESENT);
  assign oEntryPoint   = oEntryValid ? entry_q : '0;
  assign oEntryChannel = oEntryValid ? cur_ch_q : '0;
  assign oPending      = pend_q;
  assign oOverrun      = ovr_q;
  assign oBusy         = (|iTrigger) | (|pend_q) | (state_q != S_IDLE);

endmodule
